instr_fetch_decode: RTL

- Fetch stage directly upstream of the multicycle control unit.
- On a fetch request it reads one 32-bit RV64I instruction at the current PC over a simple req/ack memory handshake and latches it into an instruction register (IR).
- From the IR it presents opcode, funct3, funct7, register indices and the sign-extended 64-bit immediate to the control unit and datapath.
- Holds the fields stable from the ack until the next fetch completes.

---
 rtl/rv_pkg.sv | 55 +++++
 rtl/imm_gen.sv | 31 +++
 rtl/instr_fetch_decode.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RV64I definitions for the fetch/decode front end and later stages:
//   - major opcode constants
//   - immediate format enum and an opcode-to-format classifier
//   - canonical NOP encoding (addi x0, x0, 0)
//   - fetch FSM state type
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_VALID,
        ST_ERR
    } fetch_state_t;

    // Unknown opcodes fall into FMT_R so they decode to a zero immediate.
    function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
        imm_fmt_t fmt;
        case (op)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                                      fmt = FMT_S;
            OP_BRANCH:                                     fmt = FMT_B;
            OP_LUI, OP_AUIPC:                              fmt = FMT_U;
            OP_JAL:                                        fmt = FMT_J;
            default:                                       fmt = FMT_R;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Purely combinational RV64I immediate decoder. Selects the immediate layout
// from the opcode field and sign-extends from ir[31] to XLEN bits.
// R-type and unrecognised opcodes produce zero.
// Ports:
//   ir   in   32    instruction word
//   imm  out  XLEN  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     ir,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_fmt(ir[6:0]))
            FMT_I:   imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
            FMT_S:   imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   imm = {{(XLEN-32){ir[31]}}, ir[31:12], 12'b0};
            FMT_J:   imm = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
// Fetch stage feeding the multicycle control unit. A start_fetch pulse issues a
// single req/ack memory read at pc_in; the returned word is latched into the
// instruction register (IR) and decoded combinationally into the fields the
// control unit and datapath consume. Fields only change when a new fetch
// completes, so they stay stable while the instruction executes.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   defined   - a watchdog aborts a fetch to ERR after TIMEOUT_CYCLES cycles
//               in WAIT without an ack (an ack on the last cycle still wins).
//   undefined - WAIT lasts until the ack arrives.
//
// Ports:
//   clk          in   1     system clock, rising edge
//   reset        in   1     asynchronous active-low reset
//   start_fetch  in   1     fetch request pulse from the control unit
//   pc_in        in   XLEN  fetch address, sampled with start_fetch
//   mem_req      out  1     memory read request, held until ack
//   mem_addr     out  XLEN  registered fetch address
//   mem_ack      in   1     read data valid
//   mem_rdata    in   ILEN  instruction word
//   instr_valid  out  1     IR holds a completed fetch
//   busy         out  1     fetch in progress
//   fault        out  1     misaligned PC or timeout, sticky until next fetch
//   opcode, funct3, funct7, rs1, rs2, rd   out   IR fields
//   imm          out  XLEN  sign-extended immediate
// -----------------------------------------------------------------------------
module instr_fetch_decode
    import rv_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int ILEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_fetch,
    input  logic [XLEN-1:0] pc_in,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [ILEN-1:0] mem_rdata,
    output logic            instr_valid,
    output logic            busy,
    output logic            fault,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("instr_fetch_decode: TIMEOUT_CYCLES must be at least 2");
    end

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [ILEN-1:0] ir;
    logic            accept;
    logic            load_ir;

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Next-state logic. mem_ack is only honoured in WAIT, i.e. while mem_req
    // is high; start_fetch is only honoured outside WAIT.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_ir    = 1'b0;
        case (state)
            ST_IDLE, ST_VALID, ST_ERR: begin
                if (start_fetch) begin
                    if (pc_in[1:0] == 2'b00) begin
                        state_next = ST_WAIT;
                        accept     = 1'b1;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_next = ST_VALID;
                    load_ir    = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt == CNT_LIMIT) begin
                    state_next = ST_ERR;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            ir       <= ILEN'(NOP_INSTR);
        end else begin
            state <= state_next;
            if (accept) begin
                mem_addr <= pc_in;
            end
            if (load_ir) begin
                ir <= mem_rdata;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Counts WAIT cycles without ack; cleared whenever a new request starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT && !mem_ack && wait_cnt != CNT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // Status outputs derive from state so reset drops mem_req asynchronously.
    assign mem_req     = (state == ST_WAIT);
    assign busy        = (state == ST_WAIT);
    assign instr_valid = (state == ST_VALID);
    assign fault       = (state == ST_ERR);

    // Decode strictly from IR, never from mem_rdata.
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .ir  (ir[31:0]),
        .imm (imm)
    );

endmodule
